// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte/block data path.
// Contents:
//   BLOCK_BYTES      - bytes per AES block (16)
//   byte_t / block_t - one byte lane, and a packed 16-lane block (lane 0 in the LSBs)
//   blk_state_t      - state encoding shared by the 1-to-16 deserializer and
//                      the 16-to-1 serializer
package aes_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef logic [7:0] byte_t;
  typedef byte_t [15:0] block_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } blk_state_t;

endpackage

// File: rtl/mod_reg16_1to16.sv
// Byte-serial to 128-bit block deserializer.
// Collects 16 accepted bytes into a block register and presents them in
// parallel until the consumer acknowledges the block.
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous reset, active-high (1 = reset)
//   flush      in   synchronous discard of the current partial or full block
//   i          in   W-bit input byte
//   wr_en      in   byte write request
//   rd_ack     in   consumer has taken o; frees the block register
//   o          out  N x W assembled block, o[0] = first byte written
//   reg_full   out  block complete and o valid
//   reg_empty  out  no bytes held
//   n_wr       out  bytes held in the current partial block (0..15)
//   overflow   out  sticky: a write arrived while the block was full
module mod_reg16_1to16
  import aes_pkg::*;
#(
  parameter int N = BLOCK_BYTES,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic [W-1:0]        i,
  input  logic                wr_en,
  input  logic                rd_ack,
  output logic [N-1:0][W-1:0] o,
  output logic                reg_full,
  output logic                reg_empty,
  output logic [3:0]          n_wr,
  output logic                overflow
);

  localparam logic [3:0] LAST_LANE = 4'(N - 1);

  blk_state_t          state;
  blk_state_t          state_nxt;
  logic [3:0]          n_wr_nxt;
  logic                accept;
  logic                ovf_set;
  logic [N-1:0][W-1:0] block_q;

  // Next-state logic. flush outranks everything; a write in FULL is never
  // accepted but flags overflow, even when rd_ack releases the block in the
  // same cycle. The 4-bit counter wraps 15->0 naturally on the 16th byte.
  always_comb begin
    state_nxt = state;
    n_wr_nxt  = n_wr;
    accept    = 1'b0;
    ovf_set   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      n_wr_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (wr_en) begin
            accept    = 1'b1;
            state_nxt = FILLING;
            n_wr_nxt  = n_wr + 4'd1;
          end
        end
        FILLING: begin
          if (wr_en) begin
            accept   = 1'b1;
            n_wr_nxt = n_wr + 4'd1;
            if (n_wr == LAST_LANE) begin
              state_nxt = FULL;
            end
          end
        end
        FULL: begin
          if (wr_en) begin
            ovf_set = 1'b1;
          end
          if (rd_ack) begin
            state_nxt = EMPTY;
            n_wr_nxt  = '0;
          end
        end
        default: begin
          state_nxt = EMPTY;
          n_wr_nxt  = '0;
        end
      endcase
    end
  end

  // Control registers: state, write counter and the sticky overflow flag.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= EMPTY;
      n_wr     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      n_wr  <= n_wr_nxt;
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // Block register: the counter doubles as the lane select. Lanes are never
  // cleared except by reset, so a released or flushed block keeps its data.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      block_q <= '0;
    end else if (accept) begin
      block_q[n_wr] <= i;
    end
  end

  assign o         = block_q;
  assign reg_full  = (state == FULL);
  assign reg_empty = (state == EMPTY);

endmodule

// File: tb/tb_mod_reg16_1to16.sv
// Self-checking bench for mod_reg16_1to16: directed scenarios plus a random
// phase, all checked every cycle against a byte-array model of the block.
module tb_mod_reg16_1to16;
  import aes_pkg::*;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic [7:0] i;
  logic       wr_en;
  logic       rd_ack;
  block_t     o;
  logic       reg_full;
  logic       reg_empty;
  logic [3:0] n_wr;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  // Behavioural model: held bytes, count, full flag, sticky overflow.
  byte_t m_lane [16];
  int    m_cnt;
  bit    m_full;
  bit    m_ovf;

  mod_reg16_1to16 dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .i         (i),
    .wr_en     (wr_en),
    .rd_ack    (rd_ack),
    .o         (o),
    .reg_full  (reg_full),
    .reg_empty (reg_empty),
    .n_wr      (n_wr),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update: flush discards, a full block only reacts to rd_ack (and
  // flags writes), otherwise a write lands in the next free lane.
  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int k = 0; k < 16; k++) m_lane[k] <= 8'h00;
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (flush) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
    end else if (m_full) begin
      if (wr_en) m_ovf <= 1'b1;
      if (rd_ack) m_full <= 1'b0;
    end else if (wr_en) begin
      m_lane[m_cnt] <= i;
      if (m_cnt == 15) begin
        m_cnt  <= 0;
        m_full <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset, all outputs against the model.
  always @(negedge clk) begin
    if (check_en && !resetn) begin
      block_t exp_o;
      for (int k = 0; k < 16; k++) exp_o[k] = m_lane[k];
      checkOutput("model_o", o, exp_o);
      checkOutput("model_reg_full", 128'(reg_full), 128'(m_full));
      checkOutput("model_reg_empty", 128'(reg_empty), 128'(!m_full && m_cnt == 0));
      checkOutput("model_n_wr", 128'(n_wr), 128'(m_cnt));
      checkOutput("model_overflow", 128'(overflow), 128'(m_ovf));
    end
  end

  // Drive one cycle of inputs; returns just after the edge that consumed them.
  task automatic applyStimulus(input bit w, input logic [7:0] d, input bit ack,
                               input bit fl);
    @(negedge clk);
    wr_en  = w;
    i      = d;
    rd_ack = ack;
    flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_o"}, o, 128'h0);
    checkOutput({tag, "_reg_full"}, 128'(reg_full), 128'h0);
    checkOutput({tag, "_reg_empty"}, 128'(reg_empty), 128'h1);
    checkOutput({tag, "_n_wr"}, 128'(n_wr), 128'h0);
    checkOutput({tag, "_overflow"}, 128'(overflow), 128'h0);
  endtask

  initial begin
    logic [7:0] rnd [16];
    resetn = 1'b1;
    flush  = 1'b0;
    i      = 8'h00;
    wr_en  = 1'b0;
    rd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    resetn   = 1'b0;
    check_en = 1'b1;

    // Fill 0x00..0x0F on consecutive cycles
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      if (k == 14) checkOutput("fill_not_full_yet", 128'(reg_full), 128'h0);
    end
    checkOutput("fill_reg_full", 128'(reg_full), 128'h1);
    checkOutput("fill_o", o, 128'h0f0e0d0c0b0a09080706050403020100);
    checkOutput("fill_n_wr", 128'(n_wr), 128'h0);
    checkOutput("fill_reg_empty", 128'(reg_empty), 128'h0);

    // Hold and release
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("hold_o", o, 128'h0f0e0d0c0b0a09080706050403020100);
    checkOutput("hold_overflow", 128'(overflow), 128'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("release_reg_full", 128'(reg_full), 128'h0);
    checkOutput("release_reg_empty", 128'(reg_empty), 128'h1);
    checkOutput("release_overflow", 128'(overflow), 128'h1);
    checkOutput("release_o_kept", o, 128'h0f0e0d0c0b0a09080706050403020100);

    // Gapped writes 0x10..0x1F
    for (int k = 0; k < 16; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      checkOutput("gap_n_wr", 128'(n_wr), 128'((k + 1) % 16));
      checkOutput("gap_reg_full", 128'(reg_full), 128'(k == 15));
    end
    checkOutput("gap_o15", 128'(o[15]), 128'h1f);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a simultaneous write
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("flush_n_wr", 128'(n_wr), 128'h0);
    checkOutput("flush_reg_empty", 128'(reg_empty), 128'h1);
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 8'(8'hF0 + k), 1'b0, 1'b0);
    checkOutput("flush_refill_o0", 128'(o[0]), 128'hf0);
    checkOutput("flush_refill_full", 128'(reg_full), 128'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-fill
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    #2 resetn = 1'b1;
    #1 checkReset("async_reset");
    @(negedge clk);
    resetn = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rnd[k] = 8'($urandom);
      applyStimulus(1'b1, rnd[k], 1'b0, 1'b0);
    end
    checkOutput("refill_full", 128'(reg_full), 128'h1);
    for (int k = 0; k < 16; k++) checkOutput("refill_lane", 128'(o[k]), 128'(rnd[k]));

    // Back-to-back: ack on the first FULL cycle, then write immediately
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("b2b_o0", 128'(o[0]), 128'h3c);
    checkOutput("b2b_n_wr", 128'(n_wr), 128'h1);
    checkOutput("b2b_overflow", 128'(overflow), 128'h0);

    // Random phase, checked by the model compare process
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 40) == 0));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
